// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data port share one variable-latency memory.
// Data requests win by default; an instruction waiting behind MAX_D_STREAK data grants goes next.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   i_addr_i,
    input  logic                    i_read_i,
    output logic [DATA_WIDTH-1:0]   i_rdata_o,
    output logic                    i_ready_o,

    input  logic [ADDR_WIDTH-1:0]   d_addr_i,
    input  logic [DATA_WIDTH-1:0]   d_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb_i,
    input  logic                    d_write_i,
    input  logic                    d_read_i,
    output logic [DATA_WIDTH-1:0]   d_rdata_o,
    output logic                    d_ready_o,

    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
    output logic                    mem_write_o,
    output logic                    mem_read_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    mem_ready_i,

    output logic [31:0]             i_grant_cnt_o,
    output logic [31:0]             d_grant_cnt_o
);

    localparam int SW     = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

    state_t            state;
    logic [SW-1:0]     d_streak;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              write_q;

    logic d_req;
    logic pick_d;

    // Data wins unless the fetch has already waited out a full data streak.
    assign d_req  = d_read_i | d_write_i;
    assign pick_d = d_req && !(i_read_i && (d_streak == STREAK_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            d_streak      <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            write_q       <= 1'b0;
            i_grant_cnt_o <= '0;
            d_grant_cnt_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state   <= D_BUSY;
                        addr_q  <= d_addr_i;
                        write_q <= d_write_i;
                        wdata_q <= d_write_i ? d_wdata_i : '0;
                        wstrb_q <= d_write_i ? d_wstrb_i : '0;
                        if (!i_read_i)
                            d_streak <= '0;
                        else if (d_streak != STREAK_MAX)
                            d_streak <= d_streak + 1'b1;
                    end else if (i_read_i) begin
                        state    <= I_BUSY;
                        addr_q   <= i_addr_i;
                        write_q  <= 1'b0;
                        wdata_q  <= '0;
                        wstrb_q  <= '0;
                        d_streak <= '0;
                    end
                end
                I_BUSY: begin
                    if (mem_ready_i) begin
                        state         <= IDLE;
                        i_grant_cnt_o <= i_grant_cnt_o + 32'd1;
                    end
                end
                D_BUSY: begin
                    if (mem_ready_i) begin
                        state         <= IDLE;
                        d_grant_cnt_o <= d_grant_cnt_o + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_wstrb_o = wstrb_q;
    assign mem_write_o = (state == D_BUSY) && write_q;
    assign mem_read_o  = (state == I_BUSY) || ((state == D_BUSY) && !write_q);

    // Completion is passed straight through so the requester sees it in the memory's ready cycle.
    assign i_ready_o = (state == I_BUSY) && mem_ready_i;
    assign d_ready_o = (state == D_BUSY) && mem_ready_i;
    assign i_rdata_o = i_ready_o ? mem_rdata_i : '0;
    assign d_rdata_o = d_ready_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a simple fixed-latency memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr_i;
    logic        i_read_i;
    logic [31:0] i_rdata_o;
    logic        i_ready_o;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [3:0]  d_wstrb_i;
    logic        d_write_i;
    logic        d_read_i;
    logic [31:0] d_rdata_o;
    logic        d_ready_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_write_o;
    logic        mem_read_o;
    logic [31:0] rdata_val;
    logic        mem_ready_i;
    logic [31:0] i_grant_cnt_o;
    logic [31:0] d_grant_cnt_o;

    int checks = 0;
    int errors = 0;

    // Memory model: ready after mem_lat busy cycles, or driven by hand in manual mode.
    logic [7:0] mem_cnt = 8'd0;
    logic [7:0] mem_lat = 8'd1;
    logic       manual_mode = 1'b0;
    logic       manual_ready = 1'b0;

    assign mem_ready_i = manual_mode ? manual_ready
                       : ((mem_read_o | mem_write_o) && (mem_cnt == mem_lat));

    always @(posedge clk) begin
        if (!(mem_read_o | mem_write_o) || mem_ready_i)
            mem_cnt <= 8'd0;
        else
            mem_cnt <= mem_cnt + 8'd1;
    end

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_addr_i(i_addr_i), .i_read_i(i_read_i), .i_rdata_o(i_rdata_o), .i_ready_o(i_ready_o),
        .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_wstrb_i(d_wstrb_i),
        .d_write_i(d_write_i), .d_read_i(d_read_i), .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_write_o(mem_write_o), .mem_read_o(mem_read_o), .mem_rdata_i(rdata_val),
        .mem_ready_i(mem_ready_i),
        .i_grant_cnt_o(i_grant_cnt_o), .d_grant_cnt_o(d_grant_cnt_o)
    );

    // Per-cycle trace filled by applyStimulus, cycle 0 being the cycle the requests are first seen.
    logic        tr_read   [64];
    logic        tr_write  [64];
    logic        tr_iready [64];
    logic        tr_dready [64];
    logic [31:0] tr_addr   [64];
    logic [31:0] tr_wdata  [64];
    logic [3:0]  tr_wstrb  [64];
    logic [31:0] tr_irdata [64];
    logic [31:0] tr_drdata [64];
    logic [63:0] order_code;
    logic        overlap;
    int          change_cycle = -1;
    logic [31:0] change_addr  = 32'h0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clearInputs();
        i_addr_i  = '0; i_read_i  = 1'b0;
        d_addr_i  = '0; d_wdata_i = '0; d_wstrb_i = '0;
        d_write_i = 1'b0; d_read_i = 1'b0;
    endtask

    // Leaves the caller 1 time unit after the edge that sampled rst=1.
    task automatic applyReset();
        clearInputs();
        manual_mode = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Runs a fixed window, acting as both requesters: each drops its request after its last ready.
    task automatic applyStimulus(input int i_n, input int d_n, input int n_cycles);
        int i_left;
        int d_left;
        bit got_i;
        bit got_d;
        i_left     = i_n;
        d_left     = d_n;
        order_code = '0;
        overlap    = 1'b0;
        for (int c = 0; c < n_cycles; c++) begin
            @(negedge clk);
            tr_read[c]   = mem_read_o;
            tr_write[c]  = mem_write_o;
            tr_iready[c] = i_ready_o;
            tr_dready[c] = d_ready_o;
            tr_addr[c]   = mem_addr_o;
            tr_wdata[c]  = mem_wdata_o;
            tr_wstrb[c]  = mem_wstrb_o;
            tr_irdata[c] = i_rdata_o;
            tr_drdata[c] = d_rdata_o;
            got_i = i_ready_o;
            got_d = d_ready_o;
            if (got_i && got_d) overlap = 1'b1;
            if (got_i) begin order_code = {order_code[59:0], 4'h1}; i_left--; end
            if (got_d) begin order_code = {order_code[59:0], 4'hD}; d_left--; end
            @(posedge clk); #1;
            if (got_i && i_left == 0) i_read_i = 1'b0;
            if (got_d && d_left == 0) begin d_read_i = 1'b0; d_write_i = 1'b0; end
            if (c == change_cycle) d_addr_i = change_addr;
        end
        checkOutput("i_done", 64'(i_left), 64'd0);
        checkOutput("d_done", 64'(d_left), 64'd0);
    endtask

    initial begin
        logic [7:0] rd_vec;
        logic [7:0] rdy_vec;
        logic       any_read;

        clearInputs();
        rdata_val = 32'h0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst_mem_read",  64'(mem_read_o),  64'd0);
        checkOutput("rst_mem_write", 64'(mem_write_o), 64'd0);
        checkOutput("rst_mem_addr",  64'(mem_addr_o),  64'd0);
        checkOutput("rst_i_cnt",     64'(i_grant_cnt_o), 64'd0);
        checkOutput("rst_d_cnt",     64'(d_grant_cnt_o), 64'd0);

        // mem_ready_i while idle must be ignored
        @(posedge clk); #1;
        rst = 1'b0;
        manual_mode = 1'b1; manual_ready = 1'b1; rdata_val = 32'h1234;
        @(negedge clk);
        checkOutput("idle_ready_i", 64'(i_ready_o), 64'd0);
        checkOutput("idle_ready_d", 64'(d_ready_o), 64'd0);
        checkOutput("idle_rdata_d", 64'(d_rdata_o), 64'd0);
        @(posedge clk); #1;
        manual_ready = 1'b0;
        @(negedge clk);
        checkOutput("idle_cnt_d", 64'(d_grant_cnt_o), 64'd0);

        // Single fetch, latency 5
        @(posedge clk); #1;
        applyReset();
        mem_lat = 8'd5; rdata_val = 32'h0050_0093;
        i_addr_i = 32'h40; i_read_i = 1'b1;
        applyStimulus(1, 0, 12);
        for (int c = 0; c < 8; c++) begin
            rd_vec[c]  = tr_read[c];
            rdy_vec[c] = tr_iready[c];
        end
        checkOutput("f_read_trace",  64'(rd_vec),  64'h7E);
        checkOutput("f_ready_trace", 64'(rdy_vec), 64'h40);
        checkOutput("f_rdata",  64'(tr_irdata[6]), 64'h0050_0093);
        checkOutput("f_addr",   64'(tr_addr[1]),   64'h40);
        checkOutput("f_wstrb",  64'(tr_wstrb[1]),  64'h0);
        checkOutput("f_write",  64'(tr_write[3]),  64'h0);
        checkOutput("f_i_cnt",  64'(i_grant_cnt_o), 64'd1);
        checkOutput("f_d_cnt",  64'(d_grant_cnt_o), 64'd0);

        // Simultaneous fetch and store, latency 2
        applyReset();
        mem_lat = 8'd2; rdata_val = 32'h13;
        i_addr_i = 32'h10; i_read_i = 1'b1;
        d_addr_i = 32'h200; d_wdata_i = 32'hDEAD_BEEF; d_wstrb_i = 4'hF; d_write_i = 1'b1;
        applyStimulus(1, 1, 16);
        checkOutput("s_write1",  64'(tr_write[1]), 64'd1);
        checkOutput("s_read1",   64'(tr_read[1]),  64'd0);
        checkOutput("s_addr1",   64'(tr_addr[1]),  64'h200);
        checkOutput("s_wdata1",  64'(tr_wdata[1]), 64'hDEAD_BEEF);
        checkOutput("s_wstrb1",  64'(tr_wstrb[1]), 64'hF);
        checkOutput("s_dready3", 64'(tr_dready[3]), 64'd1);
        checkOutput("s_read4",   64'(tr_read[4]),  64'd0);
        checkOutput("s_read5",   64'(tr_read[5]),  64'd1);
        checkOutput("s_addr5",   64'(tr_addr[5]),  64'h10);
        checkOutput("s_wstrb5",  64'(tr_wstrb[5]), 64'h0);
        checkOutput("s_iready7", 64'(tr_iready[7]), 64'd1);
        checkOutput("s_irdata7", 64'(tr_irdata[7]), 64'h13);
        checkOutput("s_drdata7", 64'(tr_drdata[7]), 64'h0);
        checkOutput("s_order",   order_code, 64'hD1);
        checkOutput("s_overlap", 64'(overlap), 64'd0);

        // Fetch held against six back-to-back loads, latency 1
        applyReset();
        mem_lat = 8'd1; rdata_val = 32'h55;
        i_addr_i = 32'h80; i_read_i = 1'b1;
        d_addr_i = 32'h400; d_read_i = 1'b1;
        applyStimulus(1, 6, 40);
        checkOutput("st_order",   order_code, 64'hDDDD1DD);
        checkOutput("st_d_cnt",   64'(d_grant_cnt_o), 64'd6);
        checkOutput("st_i_cnt",   64'(i_grant_cnt_o), 64'd1);
        checkOutput("st_overlap", 64'(overlap), 64'd0);

        // Read and write together, address changed mid-transaction, latency 3
        applyReset();
        mem_lat = 8'd3;
        d_addr_i = 32'h300; d_wdata_i = 32'h1234_5678; d_wstrb_i = 4'h3;
        d_read_i = 1'b1; d_write_i = 1'b1;
        change_cycle = 2; change_addr = 32'h999;
        applyStimulus(0, 1, 10);
        change_cycle = -1;
        any_read = 1'b0;
        for (int c = 0; c < 10; c++) any_read = any_read | tr_read[c];
        checkOutput("rw_write1", 64'(tr_write[1]), 64'd1);
        checkOutput("rw_noread", 64'(any_read),    64'd0);
        checkOutput("rw_addr4",  64'(tr_addr[4]),  64'h300);
        checkOutput("rw_wstrb1", 64'(tr_wstrb[1]), 64'h3);
        checkOutput("rw_dready", 64'(tr_dready[4]), 64'd1);
        checkOutput("rw_d_cnt",  64'(d_grant_cnt_o), 64'd1);

        // Reset two cycles into a load, then a late memory ready
        applyReset();
        manual_mode = 1'b1; manual_ready = 1'b0;
        d_addr_i = 32'h44; d_read_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("ra_busy", 64'(mem_read_o), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1; d_read_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ra_idle", 64'(mem_read_o), 64'd0);
        @(posedge clk); #1;
        manual_ready = 1'b1;
        @(negedge clk);
        checkOutput("ra_dready", 64'(d_ready_o), 64'd0);
        @(posedge clk); #1;
        manual_ready = 1'b0;
        @(negedge clk);
        checkOutput("ra_d_cnt", 64'(d_grant_cnt_o), 64'd0);
        checkOutput("ra_i_cnt", 64'(i_grant_cnt_o), 64'd0);
        @(posedge clk); #1;
        manual_mode = 1'b0; mem_lat = 8'd2; rdata_val = 32'hCAFE_0001;
        i_addr_i = 32'h8; i_read_i = 1'b1;
        applyStimulus(1, 0, 10);
        checkOutput("ra_f_addr",  64'(tr_addr[1]),   64'h8);
        checkOutput("ra_f_ready", 64'(tr_iready[3]), 64'd1);
        checkOutput("ra_f_rdata", 64'(tr_irdata[3]), 64'hCAFE_0001);
        checkOutput("ra_f_i_cnt", 64'(i_grant_cnt_o), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 32, address width; DATA_WIDTH, default 32, data width; MAX_D_STREAK, default 4, max consecutive data grants while an instruction request waits.
REQ-002 Ports SHALL be: clk, input, 1, sole clock; rst, input, 1, synchronous active-high reset.
REQ-003 i_addr_i, input, ADDR_WIDTH: fetch address; i_read_i, input, 1: fetch request; i_rdata_o, output, DATA_WIDTH: fetch data; i_ready_o, output, 1: fetch completion pulse.
REQ-004 d_addr_i, input, ADDR_WIDTH; d_wdata_i, input, DATA_WIDTH; d_wstrb_i, input, DATA_WIDTH/8; d_write_i, input, 1; d_read_i, input, 1; d_rdata_o, output, DATA_WIDTH; d_ready_o, output, 1: core data port.
REQ-005 mem_addr_o, output, ADDR_WIDTH; mem_wdata_o, output, DATA_WIDTH; mem_wstrb_o, output, DATA_WIDTH/8; mem_write_o, output, 1; mem_read_o, output, 1; mem_rdata_i, input, DATA_WIDTH; mem_ready_i, input, 1: shared variable-latency memory port.
REQ-006 i_grant_cnt_o, d_grant_cnt_o, output, 32 each: completed-transaction counters.

Function
REQ-007 Requester protocol: request level held until its ready pulse; requester drops or changes request on the edge at which ready is sampled high.
REQ-008 Memory protocol: mem_read_o/mem_write_o held with stable addr/wdata/wstrb until mem_ready_i=1 for one cycle; deasserted the following cycle.
REQ-009 FSM states SHALL be IDLE, I_BUSY, D_BUSY; only IDLE evaluates requests.
REQ-010 IDLE: data request (d_read_i|d_write_i) and no instruction request -> D_BUSY; instruction only -> I_BUSY; none -> stay IDLE.
REQ-011 IDLE, both pending: D_BUSY unless d_streak==MAX_D_STREAK, then I_BUSY.
REQ-012 d_streak: increments (saturating at MAX_D_STREAK) on each D grant made while i_read_i=1; clears on every I grant and on any D grant with i_read_i=0.
REQ-013 On grant, addr/wdata/wstrb/op SHALL be registered; memory outputs driven from registers from the next cycle on; requester input changes during busy ignored.
REQ-014 d_write_i and d_read_i both high: write only issued (mem_write_o=1, mem_read_o=0).
REQ-015 Latency: request seen in IDLE at cycle 0 -> mem op asserted cycle 1; completion when mem_ready_i=1 in cycle N; next grant earliest issued cycle N+2 (IDLE at N+1).
REQ-016 Busy state with mem_ready_i=1: granted port ready_o=1 combinationally same cycle, its rdata_o=mem_rdata_i; return to IDLE next edge.
REQ-017 Non-granted port: ready_o=0 and rdata_o=0 at all times; i_ready_o and d_ready_o never both 1.
REQ-018 mem_ready_i=1 in IDLE SHALL be ignored (no ready_o, no counter change).
REQ-019 Grant counters increment by 1 on each completion of their port; wrap 0xFFFFFFFF->0.
REQ-020 mem_wstrb_o=0 and mem_wdata_o=0 for read transactions.

Reset
REQ-021 rst=1 at a clock edge: state IDLE, d_streak=0, both counters=0, latched regs=0, all outputs 0 next cycle.
REQ-022 Reset mid-transaction: transaction abandoned, no ready_o issued, late mem_ready_i after reset ignored per REQ-018.
REQ-023 Synchronous only: rst changes between edges SHALL not affect outputs.

Verification
REQ-024 Fetch only, i_addr_i=0x40, mem latency 5, mem_rdata_i=0x00500093 -> mem_read_o cycles 1-6, i_ready_o=1 cycle 6 with i_rdata_o=0x00500093, i_grant_cnt_o=1.
REQ-025 Simultaneous fetch 0x10 and store 0x200 wdata 0xDEADBEEF wstrb 0xF -> store issued first with mem_write_o=1, then fetch issued two cycles after store ready; d_ready_o never overlaps i_ready_o.
REQ-026 Fetch held high plus 6 back-to-back loads, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D; d_grant_cnt_o=6, i_grant_cnt_o=1.
REQ-027 d_read_i=d_write_i=1 -> only mem_write_o asserted; d_addr_i changed mid-busy -> mem_addr_o keeps granted value.
REQ-028 rst=1 two cycles into a load, mem_ready_i pulses later -> no d_ready_o, counters 0, state IDLE; subsequent fetch completes normally.
